// File: rtl/fsqrt_iter.sv
// Multi-cycle IEEE-754 square root using a restoring digit recurrence with valid/ready handshakes.
// Optional FSQRT_ITER_RADIX4_EN retires two root bits per iteration cycle.
module fsqrt_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] var1,
  input  logic [2:0]   rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [4:0]   flags
);

  localparam int R    = MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
`ifdef FSQRT_ITER_RADIX4_EN
  localparam int STEP = 2;
  localparam int RB   = R + (R % 2);
`else
  localparam int STEP = 1;
  localparam int RB   = R;
`endif
  localparam int N_IT = RB / STEP;
  localparam int CW   = $clog2(N_IT + 1);
  localparam int SW   = $clog2(MAN_W + 1) + 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;
  state_t state;

  logic [W-1:0]      op;
  logic [2:0]        rm_r;
  logic [RB+1:0]     rem;
  logic [RB-1:0]     q;
  logic [2*RB-1:0]   rad;
  logic [EXP_W-1:0]  exp_r;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      res_n;
  logic [4:0]        flags_n;

  logic              sign;
  logic [EXP_W-1:0]  exp_f;
  logic [MAN_W-1:0]  frac;
  logic              exp_zero, is_nan, is_snan, is_zero, is_inf, special;
  logic [W-1:0]      spec_res;
  logic [4:0]        spec_flags;

  assign sign     = op[W-1];
  assign exp_f    = op[W-2:MAN_W];
  assign frac     = op[MAN_W-1:0];
  assign exp_zero = ~|exp_f;
  assign is_nan   = (&exp_f) & (|frac);
  assign is_snan  = is_nan & ~frac[MAN_W-1];
  assign is_zero  = exp_zero & ~|frac;
  assign is_inf   = (&exp_f) & ~|frac;
  assign special  = is_nan | is_zero | is_inf | sign;

  always_comb begin
    spec_res   = op;
    spec_flags = '0;
    if (is_nan) begin
      spec_res   = QNAN;
      spec_flags = {is_snan, 4'b0000};
    end else if (!is_zero && sign) begin
      spec_res   = QNAN;
      spec_flags = 5'b10000;
    end
  end

  function automatic logic [SW-1:0] norm_shift(input logic [MAN_W-1:0] f);
    norm_shift = '0;
    for (int i = 0; i < MAN_W; i++)
      if (f[i]) norm_shift = SW'(MAN_W - i);
  endfunction

  logic [SW-1:0]          sh;
  logic [MAN_W:0]         mant;
  logic [EW-1:0]          e_unb;
  logic signed [EW-1:0]   e_even, e_half;
  logic [R-1:0]           m_adj;
  logic [EXP_W-1:0]       exp_res;

  always_comb begin
    sh      = norm_shift(frac);
    mant    = exp_zero ? ({1'b0, frac} << sh) : {1'b1, frac};
    e_unb   = exp_zero ? (EW'(1) - EW'(BIAS) - EW'(sh)) : (EW'(exp_f) - EW'(BIAS));
    m_adj   = e_unb[0] ? {mant, 1'b0} : {1'b0, mant};
    e_even  = e_unb - EW'(e_unb[0]);
    e_half  = e_even >>> 1;
    exp_res = EXP_W'(e_half + EW'(BIAS));
  end

  logic [RB+1:0]   rem_c, tr;
  logic [RB-1:0]   q_c;
  logic [2*RB-1:0] rad_c;

  always_comb begin
    rem_c = rem;
    q_c   = q;
    rad_c = rad;
    tr    = '0;
    for (int k = 0; k < STEP; k++) begin
      rem_c = {rem_c[RB-1:0], rad_c[2*RB-1 -: 2]};
      rad_c = {rad_c[2*RB-3:0], 2'b00};
      tr    = {q_c, 2'b01};
      if (rem_c >= tr) begin
        rem_c = rem_c - tr;
        q_c   = {q_c[RB-2:0], 1'b1};
      end else begin
        q_c   = {q_c[RB-2:0], 1'b0};
      end
    end
  end

  logic [MAN_W:0]    mant_t, sum;
  logic              guard, sticky, inc;
  logic [EXP_W-1:0]  rnd_exp;

  always_comb begin
    mant_t = q[RB-1 -: MAN_W+1];
    guard  = q[RB-MAN_W-2];
    sticky = (|rem) | ((RB > R) ? q[0] : 1'b0);
    case (rm_r)
      3'b001, 3'b010: inc = 1'b0;
      3'b011:         inc = guard | sticky;
      3'b100:         inc = guard;
      default:        inc = guard & (sticky | mant_t[0]);
    endcase
    // The hidden bit clears only when the increment wraps the mantissa, which marks the carry-out.
    sum     = mant_t + {{MAN_W{1'b0}}, inc};
    rnd_exp = sum[MAN_W] ? exp_r : exp_r + EXP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= '0;
      op        <= '0;
      rm_r      <= '0;
      rem       <= '0;
      q         <= '0;
      rad       <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      res_n     <= '0;
      flags_n   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op       <= var1;
            rm_r     <= rm;
            in_ready <= 1'b0;
            state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (special) begin
            res_n   <= spec_res;
            flags_n <= spec_flags;
            state   <= S_DONE;
          end else begin
            rem   <= '0;
            q     <= '0;
            rad   <= {m_adj, {(2*RB-R){1'b0}}};
            exp_r <= exp_res;
            cnt   <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          rem <= rem_c;
          q   <= q_c;
          rad <= rad_c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N_IT - 1)) state <= S_ROUND;
        end
        S_ROUND: begin
          res_n   <= {1'b0, rnd_exp, sum[MAN_W-1:0]};
          flags_n <= {4'b0000, guard | sticky};
          state   <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            res       <= res_n;
            flags     <= flags_n;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
